// File: rtl/data_mem_bram.sv
// data_mem_bram: byte-lane block-RAM data memory with valid/ready request and
// response channels, misaligned access across two adjacent lines, and error
// reporting for out-of-range or disallowed accesses.
module data_mem_bram #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned LANES       = 4,
  parameter int unsigned LANE_W      = 8,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [LANES-1:0]         req_sel,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [LANES*LANE_W-1:0]  req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [LANES*LANE_W-1:0]  rsp_rdata,
  output logic                     rsp_err
);

  localparam int unsigned W     = LANES * LANE_W;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned LN_W  = ADDR_W - OFF_W;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [OFF_W-1:0]  off_c;
  logic [LN_W-1:0]   line_c;
  logic              err_c;
  logic              acc_c;
  logic              rd_en_c;
  logic [OFF_W-1:0]  src_c;
  logic              lane_we_c  [LANES];
  logic [LANE_W-1:0] lane_wd_c  [LANES];
  logic [IDX_W-1:0]  lane_idx_c [LANES];
  logic [LANE_W-1:0] lane_rd    [LANES];

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              zero_q,      zero_d;
  logic [OFF_W-1:0]  off_q,       off_d;

  // Request handshake: single-entry response stage, blocked during reset
  assign req_ready = !rst & (!rsp_valid_q | rsp_ready);
  assign acc_c     = req_valid & req_ready;
  assign rd_en_c   = acc_c & !req_we;

  // Address split and access legality
  always_comb begin
    off_c  = req_addr[OFF_W-1:0];
    line_c = req_addr[ADDR_W-1:OFF_W];
    err_c  = (line_c >= LN_W'(DEPTH))
           | ((off_c != '0) & (line_c == LN_W'(DEPTH - 1)))
           | (!MISALIGN_EN & (off_c != '0));
  end

  // Per-lane write enable, data and line index after rotation by the offset
  always_comb begin
    src_c = '0;
    for (int l = 0; l < LANES; l++) begin
      src_c         = OFF_W'(l) - off_c;
      lane_we_c[l]  = acc_c & req_we & !err_c & req_sel[src_c];
      lane_wd_c[l]  = req_wdata[32'(src_c)*LANE_W +: LANE_W];
      // Lanes below the offset spill into the next line; errors park at 0
      lane_idx_c[l] = err_c ? '0
                    : IDX_W'(line_c + ((OFF_W'(l) < off_c) ? LN_W'(1) : LN_W'(0)));
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_q;

    // One synchronous-read RAM per byte lane; output holds while not read
    always_ff @(posedge clk) begin
      if (lane_we_c[g]) mem[lane_idx_c[g]] <= lane_wd_c[g];
      if (rd_en_c)      rd_q <= mem[lane_idx_c[g]];
    end

    assign lane_rd[g] = rd_q;
  end

  // Response next state: new accept replaces, consume clears, else hold
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    zero_d      = zero_q;
    off_d       = off_q;
    if (acc_c) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_c;
      zero_d      = err_c | req_we;
      off_d       = off_c;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      zero_q      <= 1'b1;
      off_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      zero_q      <= zero_d;
      off_q       <= off_d;
    end
  end

  // Read data: un-rotate lanes by the accepted offset; zero for stores/errors
  always_comb begin
    rsp_rdata = '0;
    if (!zero_q) begin
      for (int k = 0; k < LANES; k++) begin
        rsp_rdata[k*LANE_W +: LANE_W] = lane_rd[OFF_W'(k) + off_q];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_bram.sv
// Scoreboard bench for data_mem_bram: directed requests push expected
// responses; a negedge monitor pops and compares on every consumed response.
module tb_data_mem_bram;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        r2_valid, r2_ready, r2_we;
  logic [3:0]  r2_sel;
  logic [31:0] r2_addr, r2_wdata;
  logic        r2_rsp_valid, r2_rsp_err;
  logic [31:0] r2_rdata;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   a1, a2, a_next, raise_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_bram #(.DEPTH(16), .LANES(4), .LANE_W(8), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_bram #(.DEPTH(16), .LANES(4), .LANE_W(8), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_ready(r2_ready), .req_we(r2_we),
    .req_sel(r2_sel), .req_addr(r2_addr), .req_wdata(r2_wdata), .rsp_valid(r2_rsp_valid),
    .rsp_ready(1'b1), .rsp_rdata(r2_rdata), .rsp_err(r2_rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every consumed response is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data %h err %b with empty scoreboard", rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"}, rsp_rdata & e.mask, e.data & e.mask);
        check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic [31:0] mask,
                       input logic exp_e, output int acc_cyc);
    req_valid = 1'b1;
    req_we    = we;
    req_sel   = sel;
    req_addr  = addr;
    req_wdata = wd;
    acc_cyc   = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back('{exp_d, mask, exp_e, name});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc_cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no accept expected accept within 50 cycles", name);
    end
  endtask

  task automatic ld(input string name, input logic [31:0] addr, input logic [31:0] exp_d,
                    input logic [31:0] mask = 32'hFFFF_FFFF, input logic exp_e = 1'b0);
    int a;
    issue(name, 1'b0, 4'h0, addr, 32'h0, exp_d, mask, exp_e, a);
  endtask

  task automatic st(input string name, input logic [3:0] sel, input logic [31:0] addr,
                    input logic [31:0] wd, input logic exp_e = 1'b0);
    int a;
    issue(name, 1'b1, sel, addr, wd, 32'h0, 32'hFFFF_FFFF, exp_e, a);
  endtask

  task automatic r2_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    r2_valid = 1'b1;
    r2_we    = we;
    r2_sel   = 4'hF;
    r2_addr  = addr;
    r2_wdata = wd;
    @(posedge clk);
    #1;
    r2_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sel = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    r2_valid = 1'b0; r2_we = 1'b0; r2_sel = '0; r2_addr = '0; r2_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Aligned store/load back to back
    issue("t1_st", 1'b1, 4'hF, 32'h08, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 1'b0, a1);
    issue("t1_ld", 1'b0, 4'h0, 32'h08, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, a2);
    check("t1_latency", 32'(rsp_valid), 32'd1);
    check("t1_b2b", 32'(a2 - a1), 32'd1);

    // Misaligned spill across lines 1 and 2
    st("t2_st04", 4'hF, 32'h04, 32'h5A5A_5A5A);
    st("t2_st05", 4'hF, 32'h05, 32'h4433_2211);
    ld("t2_ld04", 32'h04, 32'h3322_115A);
    ld("t2_ld08", 32'h08, 32'hDEAD_BE44);

    // Partial byte enables with offset 2
    st("t3_st00", 4'hF, 32'h00, 32'h0302_0100);
    st("t3_st02", 4'b0101, 32'h02, 32'hAABB_CCDD);
    ld("t3_ld02", 32'h02, 32'h11BB_03DD);
    ld("t3_ld00", 32'h00, 32'h03DD_0100);
    ld("t3_ld04", 32'h04, 32'h3322_11BB);

    // Errors: out of range and spill past the last line
    ld("t4_ld40", 32'h40, 32'h0, 32'hFFFF_FFFF, 1'b1);
    st("t4_st3c", 4'hF, 32'h3C, 32'h0123_4567);
    st("t4_st3d", 4'hF, 32'h3D, 32'hCAFE_F00D, 1'b1);
    ld("t4_ld3c", 32'h3C, 32'h0123_4567);
    ld("t4_ld00", 32'h00, 32'h03DD_0100);
    ld("t4_ld3d", 32'h3D, 32'h0, 32'hFFFF_FFFF, 1'b1);
    st("t4_st40", 4'hF, 32'h40, 32'h1111_1111, 1'b1);

    // Backpressure: 3 stalled cycles, then consume and accept on one edge
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    ld("t5_ld", 32'h08, 32'hDEAD_BE44);
    fork
      issue("t5_next", 1'b0, 4'h0, 32'h04, 32'h0, 32'h3322_11BB, 32'hFFFF_FFFF, 1'b0, a_next);
      begin
        for (int i = 0; i < 3; i++) begin
          check("t5_hold_valid", 32'(rsp_valid), 32'd1);
          check("t5_hold_data", rsp_rdata, 32'hDEAD_BE44);
          check("t5_hold_err", 32'(rsp_err), 32'd0);
          check("t5_req_ready", 32'(req_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        rsp_ready = 1'b1;
        raise_cyc = cyc;
      end
    join
    check("t5_same_edge", 32'(a_next), 32'(raise_cyc + 1));

    // Reset while a response is pending
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    ld("t6_drop", 32'h3C, 32'h0123_4567);
    rst = 1'b1;
    #1;
    check("t6_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("t6_valid_after_rst", 32'(rsp_valid), 32'd0);
    check("t6_rdata_after_rst", rsp_rdata, 32'd0);
    check("t6_err_after_rst", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    void'(sb.pop_back());
    rsp_ready = 1'b1;
    ld("t6_ld3c", 32'h3C, 32'h0123_4567);
    ld("t6_ld08", 32'h08, 32'hDEAD_BE44);

    // Misalignment disabled instance
    r2_req(1'b0, 32'h01, 32'h0);
    check("t4c_valid", 32'(r2_rsp_valid), 32'd1);
    check("t4c_err", 32'(r2_rsp_err), 32'd1);
    check("t4c_rdata", r2_rdata, 32'd0);
    r2_req(1'b1, 32'h00, 32'h7766_5544);
    check("t4c_st_err", 32'(r2_rsp_err), 32'd0);
    r2_req(1'b0, 32'h00, 32'h0);
    check("t4c_ld_err", 32'(r2_rsp_err), 32'd0);
    check("t4c_ld_data", r2_rdata, 32'h7766_5544);

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_bram.md
# data_mem_bram

Parametrised, handshaked successor to the combinational-read data memory. It provides byte-lane write enables and misaligned access by rotating lanes across two adjacent lines. Each lane is a synchronous-read RAM, so the block infers block RAM. Out-of-range and disallowed misaligned accesses are reported as errors instead of silently wrapping. It sits between the core's load/store unit and on-chip storage, with a valid/ready request channel and a valid/ready response channel.

## Interface
- `DEPTH`, default `DATA_MEM_DEPTH`: number of lines; must be ≥ 2.
- `LANES`, default 4: byte lanes per line; must be a power of two, ≥ 2.
- `LANE_W`, default `BYTE_LEN`: bits per lane.
- `ADDR_W`, default `XLEN`: byte address width.
- `MISALIGN_EN`, default 1: when 1, any byte offset is allowed; when 0, a nonzero offset is an error.

Derived values: `W = LANES*LANE_W`, `OFF_W = $clog2(LANES)`.

- `clk` in 1: clock.
- `rst` in 1: reset. Single clock domain, `clk`; `rst` is synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_sel` in LANES: store byte enables, relative to `req_addr`; ignored for loads.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in W: store data; byte k is written to `req_addr`+k.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid`.
- `rsp_rdata` out W: load data; byte k = mem[`req_addr`+k].
- `rsp_err` out 1: access was rejected.

## Operation
- **Accept:** `acc = req_valid & req_ready`.
- **Ready:** `req_ready = !rst & (!rsp_valid | rsp_ready)`. This is a single-entry response stage with full throughput when `rsp_ready` is held high.
- **Address split:** `off = req_addr[OFF_W-1:0]`; `line = req_addr >> OFF_W`.
- **Line selection:** lane L uses `line+1` when L < `off`, otherwise `line`.
- **Write-path rotation:** lane L takes enable `req_sel[(L-off) mod LANES]` and data byte `(L-off) mod LANES` of `req_wdata`.
- **Read-path rotation:** `rsp_rdata` byte k = lane `(k+off_q) mod LANES` output, where `off_q` is `off` registered at accept.
- **Error conditions (computed combinationally at accept):**
  - `line >= DEPTH`, or
  - `off != 0 && line == DEPTH-1` (spill past the end), or
  - `MISALIGN_EN == 0 && off != 0`.
- **Error response:** no lane is written, and the response carries `rsp_err=1` and `rsp_rdata=0`.
- **Store:** lane writes commit at the accept edge. The response has `rsp_err` as computed and `rsp_rdata=0`. `req_sel=0` is a legal store that writes nothing and still responds.
- **Load:** lanes read at the accept edge. Lane RAM read enable equals `acc & !req_we`, so RAM outputs hold while the response is stalled.
- **Response hold:** response state is registered per accepted request and held stable while `rsp_valid & !rsp_ready`.
- **Memory contents:** not reset and not initialised by this block.

## Timing
- **Reset (synchronous, `rst` high at edge):** `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, and `req_ready=0` for the whole cycle `rst` is high. Any in-flight response is dropped. Memory is unaffected, so a store accepted before reset remains written.
- **Latency:** an accept at edge N gives `rsp_valid=1` after edge N, i.e. the response is visible in cycle N+1. Loads and stores both take 1 cycle.
- **Throughput:** back-to-back accepts every cycle while `rsp_ready=1`.
- **Read after write:** a load accepted at edge N+1 after a store accepted at edge N returns the stored data.
- **Response clearing:** `rsp_valid` falls after the edge where `rsp_valid & rsp_ready` holds with no new accept.
- **Simultaneous consume and accept:** the new response replaces the old one at that edge.
- **Stall:** if `rsp_ready=0` while `rsp_valid=1`, then `req_ready=0`, and `rsp_rdata`/`rsp_err` are unchanged until consumed.

## Test plan
Parameters for all scenarios: `DEPTH=16`, `LANES=4`, `MISALIGN_EN=1` unless noted.

1. **Aligned store/load:** store `0xDEADBEEF` to addr 0x08 with `req_sel=4'b1111`, then load 0x08 → `rsp_rdata=0xDEADBEEF`, `rsp_err=0`, one cycle after each accept; back-to-back accepts with no bubble.
2. **Misaligned spill:** store `0x44332211` to 0x05 (sel `1111`), then:
   - load 0x04 → `0x332211xx` (byte 0 unchanged);
   - load 0x08 → `0xxxxxxx44` in byte 0.
3. **Partial byte enables:** store `0xAABBCCDD` to 0x02 with sel `4'b0101`.
   - Bytes at 0x02 = `0xDD` and 0x04 = `0xBB` are written.
   - Bytes 0x03 and 0x05 are unchanged, checked by reload.
4. **Errors:**
   - load 0x40 (`line=16`) → `rsp_err=1`, `rsp_rdata=0`;
   - store to 0x3D (`line 15`, `off 1`) → `rsp_err=1`, no write to line 15 or line 0;
   - with `MISALIGN_EN=0`, load 0x01 → `rsp_err=1`.
5. **Backpressure:** hold `rsp_ready=0` for 3 cycles after a load.
   - `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable, and `req_ready=0`.
   - Raising `rsp_ready` together with a pending request gives a consume and a new accept in the same edge.
6. **Reset mid-operation:** assert `rst` for 1 cycle while `rsp_valid=1`.
   - After the edge, `rsp_valid=0` and `rsp_rdata=0`, and `req_ready` is low during reset.
   - Data stored before reset reads back unchanged afterward.
